// File: rtl/instruction_queue.sv
// instruction_queue
//
// DEPTH-entry FIFO of instruction words sitting between fetch and decode.
// The head word is presented combinationally on data_out. The most recently
// consumed word is held on pre_data_out for debug and relative-branch use.
// A flush (taken branch) empties the queue without touching the debug word
// or the sticky error flags.
//
// Ports:
//   clk           rising-edge clock for all state
//   reset         synchronous active-high reset
//   write_enable  push data_in this cycle
//   data_in       fetched instruction word
//   read_enable   consume the head word this cycle
//   flush         discard every queued word this cycle
//   data_out      head word, 0 when the queue is empty
//   pre_data_out  last consumed word
//   valid         queue is non-empty
//   full          queue holds DEPTH words
//   count         number of occupied entries
//   overflow      sticky, a write was rejected because the queue was full
//   underflow     sticky, a read was attempted on an empty queue

module instruction_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write_enable,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       read_enable,
    input  logic                       flush,
    output logic [WIDTH-1:0]           data_out,
    output logic [WIDTH-1:0]           pre_data_out,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] preData_q, preData_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic push;
    logic pop;

    // Status flags and the head word come purely from registered state, so
    // decode never sees a combinational path from the fetch-side inputs.
    always_comb begin
        valid    = (count_q != '0);
        full     = (count_q == CW'(DEPTH));
        data_out = valid ? mem[rdPtr_q] : '0;
    end

    // A pop frees a slot in the same cycle, which is what lets a full queue
    // accept a write alongside a read without flagging overflow.
    always_comb begin
        pop  = read_enable & valid;
        push = write_enable & (~full | pop);
    end

    // Next-state logic. Flush only clears the occupancy bookkeeping; the
    // debug word and sticky flags deliberately survive a taken branch.
    // Pointers are power-of-two wide so they wrap on their own.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        preData_d   = preData_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_d   = rdPtr_q + AW'(1);
                preData_d = mem[rdPtr_q];
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
            if (write_enable && !push) begin
                overflow_d = 1'b1;
            end
            if (read_enable && !valid) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control and status registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            preData_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            preData_q   <= preData_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array. Contents are never reset; stale entries are hidden
    // behind count, and reset/flush block the write so nothing leaks through.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem[wrPtr_q] <= data_in;
        end
    end

    assign pre_data_out = preData_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
